// File: rtl/rand_traffic_injector.sv
// Random-traffic packet source for one mesh NoC node, driven by a free-running 16-bit Galois LFSR.
// Define RAND_INJ_SEED_EN to add seed_in/seed_load for reseeding the LFSR while idle.
module rand_traffic_injector #(
  parameter int FLIT_W    = 32,
  parameter int NODE_ID_W = 4,
  parameter int PKT_LEN   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [7:0]           rate,
  input  logic [15:0]          num_pkts,
  input  logic [NODE_ID_W-1:0] src_id,
`ifdef RAND_INJ_SEED_EN
  input  logic [15:0]          seed_in,
  input  logic                 seed_load,
`endif
  output logic [FLIT_W-1:0]    flit_out,
  output logic                 flit_valid,
  input  logic                 flit_ready,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          pkt_sent_cnt
);

  typedef enum logic [2:0] {IDLE, GAP, HEAD, BODY, TAIL} state_t;

  localparam logic [15:0] TAP_MASK = 16'h1274;
  localparam int BW = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] BODY_LAST = BW'((PKT_LEN > 2) ? PKT_LEN - 3 : 0);

  state_t              state_reg;
  logic [15:0]         lfsr_reg;
  logic [15:0]         lfsr_next;
  logic [FLIT_W-1:0]   flit_reg;
  logic                valid_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [15:0]         cnt_reg;
  logic [15:0]         seq_reg;
  logic                stop_lat_reg;
  logic [BW-1:0]       body_cnt_reg;

  logic [NODE_ID_W-1:0] dest_raw;
  logic [NODE_ID_W-1:0] dest;
  logic [FLIT_W-1:0]    head_flit;
  logic [FLIT_W-1:0]    body_flit;
  logic [FLIT_W-1:0]    tail_flit;
  logic                 xfer;
  logic                 stop_req;
  logic [15:0]          cnt_inc;

  assign lfsr_next[0] = lfsr_reg[15];
  for (genvar gi = 1; gi < 16; gi++) begin : g_lfsr
    assign lfsr_next[gi] = lfsr_reg[gi-1] ^ (TAP_MASK[gi] & lfsr_reg[15]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= 16'hFFFF;
`ifdef RAND_INJ_SEED_EN
    end else if (seed_load && state_reg == IDLE) begin
      // An all-zero seed would lock the LFSR, so substitute the reset value.
      lfsr_reg <= (seed_in == 16'h0000) ? 16'hFFFF : seed_in;
`endif
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  // A packet to ourselves is pointless; steer it to the neighbouring ID instead.
  assign dest_raw = lfsr_reg[NODE_ID_W+7:8];
  assign dest     = (dest_raw == src_id) ? (dest_raw ^ NODE_ID_W'(1)) : dest_raw;

  always_comb begin
    head_flit                   = '0;
    head_flit[31:30]            = 2'b01;
    head_flit[26 +: NODE_ID_W]  = dest;
    head_flit[22 +: NODE_ID_W]  = src_id;
    head_flit[15:0]             = seq_reg;
    body_flit                   = '0;
    body_flit[15:0]             = lfsr_reg;
    tail_flit                   = body_flit;
    tail_flit[31:30]            = 2'b10;
  end

  assign xfer     = valid_reg & flit_ready;
  assign stop_req = stop | stop_lat_reg;
  assign cnt_inc  = cnt_reg + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      flit_reg     <= '0;
      valid_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      cnt_reg      <= 16'h0000;
      seq_reg      <= 16'h0000;
      stop_lat_reg <= 1'b0;
      body_cnt_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && !stop) begin
            state_reg    <= GAP;
            busy_reg     <= 1'b1;
            cnt_reg      <= 16'h0000;
            seq_reg      <= 16'h0000;
            stop_lat_reg <= 1'b0;
          end
        end
        GAP: begin
          if (stop_req) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (rate == 8'hFF || lfsr_reg[7:0] < rate) begin
            state_reg <= HEAD;
            flit_reg  <= head_flit;
            valid_reg <= 1'b1;
          end
        end
        HEAD: begin
          if (stop) stop_lat_reg <= 1'b1;
          if (xfer) begin
            body_cnt_reg <= '0;
            if (PKT_LEN == 2) begin
              state_reg <= TAIL;
              flit_reg  <= tail_flit;
            end else begin
              state_reg <= BODY;
              flit_reg  <= body_flit;
            end
          end
        end
        BODY: begin
          if (stop) stop_lat_reg <= 1'b1;
          if (xfer) begin
            if (body_cnt_reg == BODY_LAST) begin
              state_reg <= TAIL;
              flit_reg  <= tail_flit;
            end else begin
              body_cnt_reg <= body_cnt_reg + BW'(1);
              flit_reg     <= body_flit;
            end
          end
        end
        TAIL: begin
          if (stop) stop_lat_reg <= 1'b1;
          if (xfer) begin
            valid_reg <= 1'b0;
            cnt_reg   <= cnt_inc;
            seq_reg   <= seq_reg + 16'd1;
            // Completion takes priority so done still pulses alongside a stop.
            if (num_pkts != 16'h0000 && cnt_inc == num_pkts) begin
              done_reg  <= 1'b1;
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else if (stop_req) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= GAP;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign flit_out     = flit_reg;
  assign flit_valid   = valid_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign pkt_sent_cnt = cnt_reg;

endmodule

// File: tb/tb_rand_traffic_injector.sv
// Directed bench for rand_traffic_injector: reset, no-inject, counted runs, back-pressure, stop and dest steering.
`timescale 1ns/1ps
module tb_rand_traffic_injector;

  localparam int FLIT_W    = 32;
  localparam int NODE_ID_W = 4;
  localparam int PKT_LEN   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  rate = 8'h00;
  logic [15:0] num_pkts = 16'h0000;
  logic [3:0]  src_id = 4'h0;
  logic        flit_ready = 1'b0;
  logic [31:0] flit_out;
  logic        flit_valid;
  logic        busy;
  logic        done;
  logic [15:0] pkt_sent_cnt;

  rand_traffic_injector #(
    .FLIT_W(FLIT_W), .NODE_ID_W(NODE_ID_W), .PKT_LEN(PKT_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .rate(rate),
    .num_pkts(num_pkts), .src_id(src_id), .flit_out(flit_out),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .busy(busy),
    .done(done), .pkt_sent_cnt(pkt_sent_cnt)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          passed = 0;
  logic [15:0] lfsr_m = 16'hFFFF;
  int          pos = -1;
  logic [31:0] exp_flit;
  logic [15:0] exp_cnt = 16'h0000;
  logic [15:0] exp_seq = 16'h0000;
  bit          in_gap = 1'b0;
  bit          lat = 1'b0;
  int          nflits = 0, nheads = 0, ndone = 0, nvalid = 0, bad_dest = 0;

  // Reference LFSR: shift left, feed bit 15 back into bit 0 and the tap positions.
  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    logic [15:0] n;
    n = {v[14:0], v[15]};
    if (v[15]) n = n ^ 16'h1274;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_m <= 16'hFFFF;
    else        lfsr_m <= lfsr_adv(lfsr_m);

  function automatic logic [31:0] mk_head(input logic [15:0] l, input logic [3:0] src,
                                          input logic [15:0] seq);
    logic [3:0] d;
    d = l[11:8];
    if (d == src) d[0] = ~d[0];
    return {2'b01, d, src, 6'b000000, seq};
  endfunction

  function automatic logic [31:0] mk_data(input logic [1:0] typ, input logic [15:0] l);
    return {typ, 14'h0000, l};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  // One clock: predicts the next edge from pre-edge inputs, then checks the DUT after it.
  task automatic step();
    logic pv, pr, g, dec, lat_pre, tail_x, exp_done;
    logic [31:0] pf;
    logic [15:0] pl;
    pv = flit_valid;
    pr = flit_ready;
    pf = flit_out;
    pl = lfsr_m;
    g = in_gap;
    dec = g && !stop && (rate == 8'hFF || pl[7:0] < rate);
    lat_pre = lat || (stop && pos >= 0);
    @(posedge clk);
    #1;
    lat = lat_pre;
    tail_x = pv && pr && (pos == PKT_LEN - 1);
    exp_done = 1'b0;
    if (g) begin
      chk("inject", {31'b0, flit_valid}, {31'b0, dec});
      in_gap = !(stop || dec);
    end
    if (pv && !pr) begin
      chk("hold_flit", flit_out, pf);
      chk("hold_valid", {31'b0, flit_valid}, 32'd1);
    end else if (tail_x) begin
      nflits++;
      exp_cnt = exp_cnt + 16'd1;
      exp_seq = exp_seq + 16'd1;
      pos = -1;
      exp_done = (num_pkts != 16'h0000) && (exp_cnt == num_pkts);
      in_gap = !exp_done && !lat;
      chk("tail_valid_drop", {31'b0, flit_valid}, 32'd0);
      $display("pkt %0d sent (src=%0d) done=%0b at %0t", exp_cnt, src_id, done, $time);
    end else if (pv && pr) begin
      nflits++;
      pos++;
      chk("valid_stays_high", {31'b0, flit_valid}, 32'd1);
      exp_flit = mk_data((pos == PKT_LEN - 1) ? 2'b10 : 2'b00, pl);
      chk("data_flit", flit_out, exp_flit);
    end else if (flit_valid) begin
      pos = 0;
      nheads++;
      exp_flit = mk_head(pl, src_id, exp_seq);
      if (flit_out[29:26] == src_id) bad_dest++;
      chk("head_flit", flit_out, exp_flit);
    end
    chk("done", {31'b0, done}, {31'b0, exp_done});
    chk("pkt_sent_cnt", {16'h0, pkt_sent_cnt}, {16'h0, exp_cnt});
    if (done) ndone++;
    if (flit_valid) nvalid++;
  endtask

  task automatic do_start(input bit restart);
    if (restart) begin
      exp_cnt = 16'h0000;
      exp_seq = 16'h0000;
      lat = 1'b0;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    if (restart) in_gap = 1'b1;
  endtask

  initial begin
    int f0, h0, d0, v0, idle;
    bit restarted;

    // Reset state and first LFSR advance
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flit_out", flit_out, 32'h0);
    chk("rst_flit_valid", {31'b0, flit_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_pkt_cnt", {16'h0, pkt_sent_cnt}, 32'd0);
    chk("rst_lfsr", {16'h0, dut.lfsr_reg}, 32'h0000FFFF);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("lfsr_first_edge", {16'h0, dut.lfsr_reg}, 32'h0000ED8B);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);

    // rate=0: never injects; stop in GAP returns to IDLE
    rate = 8'h00; num_pkts = 16'd0; src_id = 4'h1; flit_ready = 1'b1;
    v0 = nvalid;
    do_start(1'b1);
    chk("rate0_busy", {31'b0, busy}, 32'd1);
    repeat (1000) step();
    chk("rate0_no_valid", nvalid - v0, 32'd0);
    chk("rate0_still_busy", {31'b0, busy}, 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("rate0_stop_idle", {31'b0, busy}, 32'd0);

    // rate=FF, 3 packets back-to-back
    rate = 8'hFF; num_pkts = 16'd3; src_id = 4'h1; flit_ready = 1'b1;
    f0 = nflits; h0 = nheads; d0 = ndone; idle = 0;
    do_start(1'b1);
    for (int c = 0; c < 60 && exp_cnt != 16'd3; c++) begin
      step();
      if (!flit_valid && busy) idle++;
    end
    chk("run3_flits", nflits - f0, 32'd12);
    chk("run3_heads", nheads - h0, 32'd3);
    chk("run3_done_pulses", ndone - d0, 32'd1);
    chk("run3_gap_cycles", idle, 32'd2);
    chk("run3_cnt", {16'h0, pkt_sent_cnt}, 32'd3);
    chk("run3_busy_low", {31'b0, busy}, 32'd0);
    step();
    chk("lfsr_vs_model", {16'h0, dut.lfsr_reg}, {16'h0, lfsr_m});

    // Back-pressure: hold 5 cycles mid-body
    rate = 8'hFF; num_pkts = 16'd1; src_id = 4'h3;
    f0 = nflits; d0 = ndone;
    do_start(1'b1);
    step();
    step();
    flit_ready = 1'b0;
    repeat (5) step();
    flit_ready = 1'b1;
    for (int c = 0; c < 20 && exp_cnt != 16'd1; c++) step();
    chk("hold_flits", nflits - f0, 32'd4);
    chk("hold_done", ndone - d0, 32'd1);
    chk("hold_busy_low", {31'b0, busy}, 32'd0);

    // Stop pulse while the second flit is presented
    rate = 8'hFF; num_pkts = 16'd0; src_id = 4'h2;
    f0 = nflits; h0 = nheads;
    do_start(1'b1);
    step();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (15) step();
    chk("stop_heads", nheads - h0, 32'd1);
    chk("stop_flits", nflits - f0, 32'd4);
    chk("stop_cnt", {16'h0, pkt_sent_cnt}, 32'd1);
    chk("stop_busy_low", {31'b0, busy}, 32'd0);

    // done and stop in the same tail transfer
    rate = 8'hFF; num_pkts = 16'd1; src_id = 4'h6;
    d0 = ndone;
    do_start(1'b1);
    repeat (4) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("done_with_stop", ndone - d0, 32'd1);
    chk("done_with_stop_idle", {31'b0, busy}, 32'd0);

    // Partial rate, 3 packets
    rate = 8'h40; num_pkts = 16'd3; src_id = 4'h2;
    do_start(1'b1);
    for (int c = 0; c < 400 && exp_cnt != 16'd3; c++) step();
    chk("rate40_cnt", {16'h0, pkt_sent_cnt}, 32'd3);
    chk("rate40_busy_low", {31'b0, busy}, 32'd0);

    // 200 packets from node 5; start mid-run is ignored
    rate = 8'hFF; num_pkts = 16'd200; src_id = 4'h5;
    h0 = nheads; d0 = ndone; bad_dest = 0; restarted = 1'b0;
    do_start(1'b1);
    for (int c = 0; c < 1100 && exp_cnt != 16'd200; c++) begin
      if (exp_cnt == 16'd100 && !restarted) begin
        restarted = 1'b1;
        do_start(1'b0);
      end else begin
        step();
      end
    end
    chk("src5_no_self_dest", bad_dest, 32'd0);
    chk("src5_heads", nheads - h0, 32'd200);
    chk("src5_cnt", {16'h0, pkt_sent_cnt}, 32'd200);
    chk("src5_done", ndone - d0, 32'd1);
    chk("src5_busy_low", {31'b0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rand_traffic_injector.md
Name: rand_traffic_injector

Overview:
Random-traffic source for one mesh NoC node during stimulation runs. It owns a free-running 16-bit LFSR and decides, cycle by cycle, when to inject a packet and where to send it. It emits fixed-length packets as flits on a valid/ready link into the router's local input port. It stops after a programmed packet count or on request.

Parameters:
FLIT_W, 32, flit width in bits (minimum 32).
NODE_ID_W, 4, width of the destination and source ID fields (maximum 4).
PKT_LEN, 4, flits per packet (minimum 2: head, body..., tail).

Ports:
clk  in  1  system clock.
rst_n  in  1  reset. Asynchronous assert, active-low.
start  in  1  pulse. Begins a run. Ignored while busy=1 or when stop=1.
stop  in  1  level or pulse. Requests the end of the run; never truncates a packet.
rate  in  8  injection threshold. 0 means never inject; 8'hFF means inject at every decision.
num_pkts  in  16  packets per run. 0 means unlimited.
src_id  in  NODE_ID_W  this node's ID.
flit_out  out  FLIT_W  flit data.
flit_valid  out  1  flit_out holds a valid flit.
flit_ready  in  1  the router accepts the flit. A transfer occurs when flit_valid and flit_ready are both high on a rising clk edge.
busy  out  1  a run is in progress (state is not IDLE).
done  out  1  one-cycle pulse when num_pkts packets have been sent.
pkt_sent_cnt  out  16  packets completed in the current run.

Behaviour:
- Reset values: all outputs 0; LFSR = 16'hFFFF; FSM = IDLE; stop latch cleared.
- LFSR advances on every clk edge out of reset, in every state. Galois form:
  - new[0] = old[15].
  - new[i] = old[i-1] ^ old[15] for i in {2, 4, 5, 6, 9, 12}.
  - new[i] = old[i-1] for all other bits.
- The LFSR is never all-zero.
- FSM states: IDLE, GAP, HEAD, BODY, TAIL.
- IDLE:
  - start=1 and stop=0 → GAP.
  - On that transition, clear pkt_sent_cnt and the sequence counter, and clear the stop latch.
- GAP (one decision per cycle):
  - If stop=1 or the stop latch is set → IDLE.
  - Else if rate=8'hFF, or lfsr[7:0] < rate → HEAD. On that edge, load the head flit and set flit_valid=1.
- Head flit fields:
  - [31:30] = 2'b01.
  - [29:26] = dest, taken from lfsr[NODE_ID_W+7:8] at the decision cycle and zero-extended. If dest equals src_id, flip bit 0 of dest.
  - [25:22] = src_id, zero-extended.
  - [21:16] = 0.
  - [15:0] = sequence number.
  - Bits above 31 = 0.
- Body flit fields: [31:30] = 2'b00, [29:16] = 0, [15:0] = LFSR value at the cycle the flit is loaded.
- Tail flit fields: [31:30] = 2'b10, rest as for a body flit.
- Hold rule: flit_out and flit_valid stay stable while flit_valid=1 and flit_ready=0.
- HEAD/BODY: on each transfer, load the next flit in the same edge; flit_valid stays high.
  - There are PKT_LEN-2 body flits.
  - After the last body flit, go to TAIL. If PKT_LEN=2, HEAD goes directly to TAIL.
- TAIL, on transfer:
  - flit_valid → 0.
  - pkt_sent_cnt += 1, wrapping at 16'hFFFF.
  - Sequence counter += 1, wrapping.
  - If num_pkts≠0 and the new count equals num_pkts: done=1 for one cycle, then → IDLE.
  - Else if stop=1 or the stop latch is set → IDLE.
  - Else → GAP. The minimum gap between packets is 1 cycle.
- stop asserted in HEAD, BODY or TAIL sets the stop latch. The packet completes in full.
- done and a stop request in the same TAIL transfer: done still pulses.
- rate, num_pkts and src_id are sampled live. They should be held constant during a run.
- Timing: start high at edge N gives GAP from edge N; the first flit_valid is possible after edge N+1.
- Back-to-back packets with flit_ready=1 and rate=8'hFF: PKT_LEN flits, then 1 idle cycle, repeating.

Optional Feature:
RAND_INJ_SEED_EN
- With the macro defined: adds ports seed_in (in, 16) and seed_load (in, 1).
  - seed_load=1 while in IDLE loads the LFSR with seed_in on that edge, replacing the advance.
  - If seed_in is 0, load 16'hFFFF instead.
  - seed_load is ignored while busy=1.
- Without the macro: the ports are absent and the LFSR is seeded only by reset.

Test Plan:
1. Reset release, then one clk edge with an internal probe → LFSR = 16'hED8B. All outputs 0.
2. rate=0, num_pkts=0, start pulse, 1000 cycles → flit_valid never asserts; busy=1. Then stop → busy=0 within 1 cycle.
3. rate=8'hFF, num_pkts=3, flit_ready=1 → exactly 12 flits, typed 01,00,00,10 ×3. Head seq = 0, 1, 2. done pulses once on the last tail transfer. pkt_sent_cnt=3. busy=0 on the next cycle.
4. flit_ready=0 for 5 cycles mid-body → flit_out and flit_valid are constant across those 5 cycles. The transfer completes when flit_ready returns to 1.
5. stop pulse during the second flit of a packet → the remaining flits, including the tail, are sent, then IDLE. No new head appears.
6. src_id=4'h5, rate=8'hFF, 200 packets → no head carries dest=5. A start pulse mid-run does not reset pkt_sent_cnt.
